rv32_decode_exec_register: RTL

- Pipeline register between the decode stage and the execute stage.
- Captures the decoded instruction, control word, register-file read data and per-operand bypass selects produced in decode.
- Inserts a NOP bubble when decode signals a data or CSR hazard stall, and freezes when execute is busy.
- Drops the younger instruction on a branch/jump flush.
- Keeps optional stall/flush performance counters.

---
 rtl/rv32_decode_exec_register_pkg.sv | 60 ++++++
 rtl/rv32_decode_exec_register_perf_counter.sv | 20 ++
 rtl/rv32_decode_exec_register.sv | 84 ++++++++
 3 files changed

// File: rtl/rv32_decode_exec_register_pkg.sv
// rtl/rv32_decode_exec_register_pkg.sv - rv32_types package: instruction, control, bypass and decode/execute buffer types
package rv32_types;

  localparam int RV_XLEN          = 32;
  localparam int CORE_RF_NUM_READ = 3;

  typedef logic [31:0] rv_instr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_src_t;

  typedef enum logic [1:0] {
    NO_BYPASS   = 2'd0,
    BYPASS_EXEC = 2'd1,
    BYPASS_MEM  = 2'd2,
    BYPASS_WB   = 2'd3
  } bypass_t;

  typedef struct packed {
    logic       register_wb;
    logic       mem_read;
    logic       mem_write;
    wb_src_t    wb_result_src;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic       csr_access;
  } rv_control_t;

  // addi x0,x0,0
  localparam rv_instr_t NOP_INSTR = 32'h00000013;

  // Bubble control: no writeback, no memory access, ALU result source
  localparam rv_control_t NOP_CONTROL = '{
    register_wb:   1'b0,
    mem_read:      1'b0,
    mem_write:     1'b0,
    wb_result_src: WB_ALU,
    alu_op:        4'd0,
    alu_src_imm:   1'b0,
    branch:        1'b0,
    jump:          1'b0,
    csr_access:    1'b0
  };

  typedef struct packed {
    logic                                         valid;
    logic [RV_XLEN-1:0]                           pc;
    rv_instr_t                                    instr;
    rv_control_t                                  control;
    logic [CORE_RF_NUM_READ-1:0][RV_XLEN-1:0]     rs_data;
    bypass_t [CORE_RF_NUM_READ-1:0]               bypass;
  } decode_exec_buffer_t;

endpackage

// File: rtl/rv32_decode_exec_register_perf_counter.sv
// rtl/rv32_decode_exec_register_perf_counter.sv - rv32_perf_counter: wrapping event counter with enable
module rv32_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled edges, wrapping modulo 2^W
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rv32_decode_exec_register.sv
// rtl/rv32_decode_exec_register.sv - decode/execute pipeline register with bubble, freeze, flush; counters under RV32_PERF_COUNTERS_EN
module rv32_decode_exec_register
  import rv32_types::*;
#(
  parameter int NUM_READ   = CORE_RF_NUM_READ,
  parameter int XLEN       = RV_XLEN,
  parameter int PERF_CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           dec_valid_i,
  input  rv_instr_t                      dec_instr_i,
  input  rv_control_t                    dec_control_i,
  input  logic [NUM_READ-1:0][XLEN-1:0]  dec_rs_data_i,
  input  bypass_t [NUM_READ-1:0]         dec_bypass_i,
  input  logic [XLEN-1:0]                dec_pc_i,
  input  logic                           hazard_stall_i,
  input  logic                           exec_busy_i,
  input  logic                           flush_i,
  output logic                           decode_hold_o,
  output decode_exec_buffer_t            buff_o,
  output logic [PERF_CNT_W-1:0]          perf_stall_cnt_o,
  output logic [PERF_CNT_W-1:0]          perf_flush_cnt_o
);

  // A flush overwrites decode from fetch, so hold is released even if stalled or busy
  always_comb begin
    decode_hold_o = (hazard_stall_i | exec_busy_i) & ~flush_i;
  end

  // Priority: flush bubble > busy freeze > hazard bubble > load from decode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buff_o.valid   <= 1'b0;
      buff_o.pc      <= '0;
      buff_o.instr   <= NOP_INSTR;
      buff_o.control <= NOP_CONTROL;
      buff_o.rs_data <= '0;
      for (int i = 0; i < NUM_READ; i++) buff_o.bypass[i] <= NO_BYPASS;
    end else if (flush_i || (!exec_busy_i && hazard_stall_i)) begin
      // Bubble: pc and rs_data are don't-care and simply held
      buff_o.valid   <= 1'b0;
      buff_o.instr   <= NOP_INSTR;
      buff_o.control <= NOP_CONTROL;
      for (int i = 0; i < NUM_READ; i++) buff_o.bypass[i] <= NO_BYPASS;
    end else if (!exec_busy_i) begin
      buff_o.valid   <= dec_valid_i;
      buff_o.pc      <= dec_pc_i;
      buff_o.instr   <= dec_instr_i;
      buff_o.control <= dec_valid_i ? dec_control_i : NOP_CONTROL;
      buff_o.rs_data <= dec_rs_data_i;
      buff_o.bypass  <= dec_bypass_i;
    end
  end

`ifdef RV32_PERF_COUNTERS_EN
  logic stall_event;
  logic flush_event;

  // Stall counts only the edges where a hazard bubble is actually inserted
  always_comb begin
    stall_event = hazard_stall_i & ~exec_busy_i & ~flush_i;
    flush_event = flush_i;
  end

  rv32_perf_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (stall_event),
    .count  (perf_stall_cnt_o)
  );

  rv32_perf_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (flush_event),
    .count  (perf_flush_cnt_o)
  );
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule
